tpp_bank_ctrl: RTL

- Parametrised triple-ping-pong polyvec bank controller for the preprocess path.
- Owns role rotation across NUM_PV polyvec buffers, each split into NUM_BANKS external RAM banks.
- Routes three client ports onto the packed bank buses that go up to the test env: DP1 (WRITE role), INTT engine (COMPUTE role) and mux readout (READ role).
- Adds a switch handshake, an INTT start/busy/done FSM and a read-latency pipeline with valid flags.

---
 rtl/tpp_bank_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/tpp_bank_ctrl.sv
// Triple-ping-pong polyvec bank controller: role rotation, INTT FSM,
// client-to-bank routing and a read-latency pipeline per client port.
module tpp_bank_ctrl #(
  parameter  int DATA_WIDTH = 35,
  parameter  int NUM_PV     = 3,
  parameter  int NUM_BANKS  = 8,
  parameter  int BANK_AW    = 9,
  parameter  int RD_LAT     = 1,
  localparam int BKW        = $clog2(NUM_BANKS),
  localparam int ADDR_WIDTH = BKW + BANK_AW,
  localparam int PVW        = (NUM_PV > 1) ? $clog2(NUM_PV) : 1,
  localparam int NSLOT      = NUM_PV * NUM_BANKS
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        io_i_pre_switch,
  output logic                        io_o_switch_ack,
  output logic [PVW-1:0]              io_o_rot_ptr,
  input  logic                        io_i_intt_start,
  input  logic                        io_i_eng_done,
  output logic                        io_o_intt_busy,
  output logic                        io_o_intt_done,
  input  logic                        io_i_mux_done,
  input  logic                        io_i_dp1_wren,
  input  logic [ADDR_WIDTH-1:0]       io_i_dp1_wraddr,
  input  logic [DATA_WIDTH-1:0]       io_i_dp1_wrdata,
  input  logic                        io_i_dp1_rden,
  input  logic [ADDR_WIDTH-1:0]       io_i_dp1_rdaddr,
  output logic [DATA_WIDTH-1:0]       io_o_dp1_rddata,
  output logic                        io_o_dp1_rdvalid,
  input  logic                        io_i_eng_wren,
  input  logic [ADDR_WIDTH-1:0]       io_i_eng_wraddr,
  input  logic [DATA_WIDTH-1:0]       io_i_eng_wrdata,
  input  logic                        io_i_eng_rden,
  input  logic [ADDR_WIDTH-1:0]       io_i_eng_rdaddr,
  output logic [DATA_WIDTH-1:0]       io_o_eng_rddata,
  output logic                        io_o_eng_rdvalid,
  input  logic                        io_i_mux_rden,
  input  logic [ADDR_WIDTH-1:0]       io_i_mux_rdaddr,
  output logic [DATA_WIDTH-1:0]       io_o_mux_rddata,
  output logic                        io_o_mux_rdvalid,
  output logic [NSLOT-1:0]            tppWrEnPacked,
  output logic [NSLOT*BANK_AW-1:0]    tppWrAddrPacked,
  output logic [NSLOT*DATA_WIDTH-1:0] tppWrDataPacked,
  output logic [NSLOT*BANK_AW-1:0]    tppRdAddrPacked,
  input  logic [NSLOT*DATA_WIDTH-1:0] tppRdDataPacked
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [PVW-1:0]   ptr_q, ptr_d;
  logic [PVW-1:0]   cmp_pv, rd_pv;
  logic             pending_q, released_q;
  logic             rotate, eng_ok;

  function automatic logic [PVW-1:0] pv_dec(input logic [PVW-1:0] p);
    return (p == '0) ? PVW'(NUM_PV - 1) : p - 1'b1;
  endfunction

  assign cmp_pv = pv_dec(ptr_q);
  assign rd_pv  = pv_dec(cmp_pv);
  assign ptr_d  = (ptr_q == PVW'(NUM_PV - 1)) ? '0 : ptr_q + 1'b1;
  assign rotate = pending_q && released_q && (state_q == S_IDLE);
  assign eng_ok = (state_q == S_BUSY);

  assign io_o_switch_ack = rotate;
  assign io_o_rot_ptr    = ptr_q;
  assign io_o_intt_busy  = (state_q == S_BUSY);
  assign io_o_intt_done  = (state_q == S_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      pending_q  <= 1'b0;
      released_q <= 1'b1;
    end else if (rotate) begin
      // a mux_done here closes the old READ buffer, not the new one
      ptr_q      <= ptr_d;
      pending_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      pending_q  <= pending_q | io_i_pre_switch;
      released_q <= released_q | io_i_mux_done;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (io_i_intt_start) state_q <= S_BUSY;
        S_BUSY:  if (io_i_eng_done) state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [BKW-1:0]     dp1_wbk, eng_wbk;
  logic [BANK_AW-1:0] dp1_wa, eng_wa;
  logic               eng_we;
  logic [2:0]         rq_v;
  logic [PVW-1:0]     rq_pv [3];
  logic [BKW-1:0]     rq_bk [3];
  logic [BANK_AW-1:0] rq_ad [3];

  assign dp1_wbk = io_i_dp1_wraddr[BKW-1:0];
  assign dp1_wa  = io_i_dp1_wraddr[ADDR_WIDTH-1:BKW];
  assign eng_wbk = io_i_eng_wraddr[BKW-1:0];
  assign eng_wa  = io_i_eng_wraddr[ADDR_WIDTH-1:BKW];
  assign eng_we  = io_i_eng_wren && eng_ok;

  // port 0 = DP1 (WRITE), 1 = engine (COMPUTE), 2 = mux (READ)
  assign rq_v     = {io_i_mux_rden, io_i_eng_rden && eng_ok, io_i_dp1_rden};
  assign rq_pv[0] = ptr_q;
  assign rq_pv[1] = cmp_pv;
  assign rq_pv[2] = rd_pv;
  assign rq_bk[0] = io_i_dp1_rdaddr[BKW-1:0];
  assign rq_bk[1] = io_i_eng_rdaddr[BKW-1:0];
  assign rq_bk[2] = io_i_mux_rdaddr[BKW-1:0];
  assign rq_ad[0] = io_i_dp1_rdaddr[ADDR_WIDTH-1:BKW];
  assign rq_ad[1] = io_i_eng_rdaddr[ADDR_WIDTH-1:BKW];
  assign rq_ad[2] = io_i_mux_rdaddr[ADDR_WIDTH-1:BKW];

  for (genvar gp = 0; gp < NUM_PV; gp++) begin : g_pv
    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bk
      localparam int S = gp * NUM_BANKS + gb;
      logic       dw, ew;
      logic [2:0] rh;

      assign dw = io_i_dp1_wren && (ptr_q == PVW'(gp))
                  && (dp1_wbk == BKW'(gb));
      assign ew = eng_we && (cmp_pv == PVW'(gp))
                  && (eng_wbk == BKW'(gb));

      for (genvar p = 0; p < 3; p++) begin : g_rh
        assign rh[p] = rq_v[p] && (rq_pv[p] == PVW'(gp))
                       && (rq_bk[p] == BKW'(gb));
      end

      assign tppWrEnPacked[S] = dw | ew;
      assign tppWrAddrPacked[S*BANK_AW +: BANK_AW] =
        dw ? dp1_wa : ew ? eng_wa : '0;
      assign tppWrDataPacked[S*DATA_WIDTH +: DATA_WIDTH] =
        dw ? io_i_dp1_wrdata : ew ? io_i_eng_wrdata : '0;
      assign tppRdAddrPacked[S*BANK_AW +: BANK_AW] =
        rh[0] ? rq_ad[0] : rh[1] ? rq_ad[1] : rh[2] ? rq_ad[2] : '0;
    end
  end

  logic [RD_LAT-1:0]   vld_q [3];
  logic [PVW-1:0]      pv_q  [3][RD_LAT];
  logic [BKW-1:0]      bk_q  [3][RD_LAT];
  logic [DATA_WIDTH-1:0] rdat [3];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 3; p++) begin
        vld_q[p] <= '0;
        for (int k = 0; k < RD_LAT; k++) begin
          pv_q[p][k] <= '0;
          bk_q[p][k] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        vld_q[p][0] <= rq_v[p];
        pv_q[p][0]  <= rq_pv[p];
        bk_q[p][0]  <= rq_bk[p];
        for (int k = 1; k < RD_LAT; k++) begin
          vld_q[p][k] <= vld_q[p][k-1];
          pv_q[p][k]  <= pv_q[p][k-1];
          bk_q[p][k]  <= bk_q[p][k-1];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdat[p] = '0;
      for (int v = 0; v < NUM_PV; v++) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (vld_q[p][RD_LAT-1] && (pv_q[p][RD_LAT-1] == PVW'(v))
              && (bk_q[p][RD_LAT-1] == BKW'(b)))
            rdat[p] = tppRdDataPacked[(v*NUM_BANKS+b)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign io_o_dp1_rdvalid = vld_q[0][RD_LAT-1];
  assign io_o_eng_rdvalid = vld_q[1][RD_LAT-1];
  assign io_o_mux_rdvalid = vld_q[2][RD_LAT-1];
  assign io_o_dp1_rddata  = rdat[0];
  assign io_o_eng_rddata  = rdat[1];
  assign io_o_mux_rddata  = rdat[2];

endmodule
